program_loader: RTL and testbench

Synthesizable instruction-memory loader that fills the CPU's word-addressed instruction RAM from a byte stream and holds the core in reset until the image is complete. It is the hardware writer for the instruction memory the core fetches from, replacing file preload on FPGA builds. It sits between a byte source (UART receiver or debug link) and the imem write port, and drives the CPU's reset.

---
 rtl/program_loader.sv | 112 +++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: fills the word-addressed instruction RAM from a byte
// stream (16-bit LE word count, then LE 32-bit words) and holds the CPU in
// reset until the whole image has been written.
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;      // first three bytes of the word being assembled
  logic          done_q;
  logic          xfer;
  logic          accepting;
  logic          restartable;
  logic          hdr_bad;
  logic          last_word;
  logic [15:0]   len_full;

  assign accepting   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign restartable = (state == IDLE) || (state == DONE) || (state == ERR);
  assign xfer        = in_valid && accepting;
  assign len_full    = {in_data, len_lo};
  assign hdr_bad     = (len_full == 16'd0) || (32'(len_full) > DEPTH);
  // words_loaded doubles as the index of the word currently being assembled
  assign last_word   = (32'(words_loaded) + 32'd1) == 32'(len);

  assign in_ready = accepting;
  assign busy     = accepting;
  assign error    = (state == ERR);
  // release lags entry into DONE by one cycle so the final write lands first
  assign done     = done_q;
  assign cpu_rstn = done_q;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
      LEN_LO:          if (xfer) state_nxt = LEN_HI;
      LEN_HI:          if (xfer) state_nxt = hdr_bad ? ERR : DATA;
      DATA:            if (xfer && byte_idx == 2'd3 && last_word) state_nxt = DONE;
      default:         state_nxt = IDLE;
    endcase
  end

  // header capture, word assembly, imem write port and release flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      done_q       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      done_q <= (state == DONE) && (state_nxt == DONE);
      if (restartable && start) words_loaded <= '0;
      if (xfer) begin
        case (state)
          LEN_LO: len_lo <= in_data;
          LEN_HI: begin
            len      <= len_full;
            byte_idx <= 2'd0;
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            asm_q    <= {in_data, asm_q[23:8]};
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= {in_data, asm_q};
              words_loaded <= words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed byte streams, a byte-count based
// reference model checked every cycle, and literal expectations per scenario.
module tb_program_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_rstn, busy, done, error;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  program_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: tracks bytes accepted in the current load
  bit          m_loading = 0, m_loaded = 0, m_rel = 0, m_rej = 0, m_we = 0;
  bit          m_was;
  int          m_nb = 0, m_n = 0, m_k;
  logic [7:0]  m_nlo = 8'h00;
  logic [31:0] m_buf = 32'h0, m_wdata = 32'h0;
  logic [9:0]  m_addr = 10'h0;
  logic [10:0] m_wl = 11'h0;

  // model update on each clock edge from the inputs the DUT also sees
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_loading = 0; m_loaded = 0; m_rel = 0; m_rej = 0; m_we = 0;
      m_nb = 0; m_n = 0; m_buf = 32'h0; m_wdata = 32'h0; m_addr = 10'h0; m_wl = 11'h0;
    end else begin
      m_was = m_loaded;
      m_we  = 0;
      if (!m_loading && start) begin
        m_loading = 1; m_loaded = 0; m_rej = 0; m_nb = 0; m_wl = 11'h0;
      end else if (m_loading && in_valid) begin
        if (m_nb == 0) m_nlo = in_data;
        else if (m_nb == 1) begin
          m_n = int'({in_data, m_nlo});
          if (m_n == 0 || m_n > DEPTH) begin m_loading = 0; m_rej = 1; end
        end else begin
          m_k = m_nb - 2;
          m_buf[8*(m_k%4) +: 8] = in_data;
          if (m_k % 4 == 3) begin
            m_we = 1; m_addr = 10'(m_k/4); m_wdata = m_buf; m_wl = 11'(m_k/4 + 1);
            if (m_k/4 + 1 == m_n) begin m_loading = 0; m_loaded = 1; end
          end
        end
        m_nb++;
      end
      m_rel = m_was && m_loaded;
    end
  end

  logic [9:0]  log_a[$];
  logic [31:0] log_d[$];

  // per-cycle comparison against the model, and write logging
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_loading));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("done", 32'(done), 32'(m_rel));
    chk("cpu_rstn", 32'(cpu_rstn), 32'(m_rel));
    chk("error", 32'(error), 32'(m_rej));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    if (mem_we) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  logic [7:0] sq[$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_stream(input int gap);
    foreach (sq[i]) send_byte(sq[i], gap);
  endtask

  task automatic push_word(input logic [31:0] w);
    sq.push_back(w[7:0]);   sq.push_back(w[15:8]);
    sq.push_back(w[23:16]); sq.push_back(w[31:24]);
  endtask

  task automatic build_n2();
    sq.delete();
    sq.push_back(8'h02); sq.push_back(8'h00);
    push_word(32'h00000013);
    push_word(32'h00100093);
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_n2(input string tag);
    chk({tag, "_nwr"}, 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk({tag, "_a0"}, 32'(log_a[0]), 32'h0);
      chk({tag, "_d0"}, log_d[0], 32'h00000013);
      chk({tag, "_a1"}, 32'(log_a[1]), 32'h1);
      chk({tag, "_d1"}, log_d[1], 32'h00100093);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd1);
    chk({tag, "_wl"}, 32'(words_loaded), 32'd2);
  endtask

  logic [31:0] w, last_w;

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // N=2 back-to-back
    pulse_start();
    build_n2();
    log_a.delete(); log_d.delete();
    send_stream(0);
    settle();
    check_n2("b2b");

    // restart from DONE, same stream with gaps between bytes
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    log_a.delete(); log_d.delete();
    send_stream(1);
    settle();
    check_n2("gap");

    // N=0 rejected, then recover with N=1
    pulse_start();
    log_a.delete(); log_d.delete();
    sq.delete(); sq.push_back(8'h00); sq.push_back(8'h00);
    send_stream(0);
    settle();
    chk("n0_error", 32'(error), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("n0_nwr", 32'(log_a.size()), 32'd0);
    pulse_start();
    chk("n1_err_clr", 32'(error), 32'd0);
    sq.delete(); sq.push_back(8'h01); sq.push_back(8'h00);
    push_word(32'hDEADBEEF);
    send_stream(0);
    settle();
    chk("n1_done", 32'(done), 32'd1);
    chk("n1_nwr", 32'(log_a.size()), 32'd1);
    if (log_d.size() == 1) chk("n1_d0", log_d[0], 32'hDEADBEEF);

    // N=1025 rejected
    pulse_start();
    log_a.delete(); log_d.delete();
    sq.delete(); sq.push_back(8'h01); sq.push_back(8'h04);
    send_stream(0);
    settle();
    chk("n1025_error", 32'(error), 32'd1);
    chk("n1025_nwr", 32'(log_a.size()), 32'd0);

    // N=1024 full image, with a start pulse mid-DATA that must be ignored
    pulse_start();
    sq.delete(); sq.push_back(8'h00); sq.push_back(8'h04);
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'(i) * 32'h9E3779B1 + 32'h00001234;
      push_word(w);
      last_w = w;
    end
    foreach (sq[i]) begin
      send_byte(sq[i], 0);
      if (i == 101) pulse_start();
    end
    settle();
    chk("full_nwr", 32'(log_a.size()), 32'd1024);
    chk("full_last_a", 32'(log_a[$]), 32'h3FF);
    chk("full_last_d", log_d[$], last_w);
    chk("full_done", 32'(done), 32'd1);
    chk("full_wl", 32'(words_loaded), 32'h400);

    // reset after 5 data bytes of an N=2 load
    pulse_start();
    log_a.delete(); log_d.delete();
    build_n2();
    for (int i = 0; i < 7; i++) send_byte(sq[i], 0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_wl", 32'(words_loaded), 32'd0);
    chk("mid_rst_flags", {29'd0, done, error, cpu_rstn}, 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_nwr", 32'(log_a.size()), 32'd1);
    log_a.delete(); log_d.delete();
    pulse_start();
    send_stream(0);
    settle();
    check_n2("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
